// File: rtl/mst_bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   ADDR_W / DATA_W : slave bus address and write-data widths
//   CNT_W           : width of the optional grant timeout counter
//   arb_state_e     : arbiter FSM state encoding (ARB_IDLE, ARB_GNT_M0, ARB_GNT_M1)
//   owner_e         : identifies the master that was granted most recently
package mst_bus_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_GNT_M0 = 2'b01,
    ARB_GNT_M1 = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

endpackage

// File: rtl/mst_bus_arbiter_if.sv
// Bus bundle between two masters (m0 = CPU, m1 = DMA), the arbiter and the
// shared slave side.
//   mX_bus_req / mX_bus_grant     : request from / grant to master X
//   mX_mst2slv_addr/_data/_wr/_rd : master X address, write data, strobes
//   s_mst2slv_addr/_data/_wr/_rd  : arbitrated bus towards the slaves
//   arb_owner                     : one-hot owner {m1,m0}, 2'b00 when idle
// Modports:
//   slave  : the arbiter's view (serves the masters, drives the slave bus)
//   master : the masters' / environment view
interface mst_bus_arbiter_if;
  import mst_bus_arbiter_pkg::*;

  logic              m0_bus_req;
  logic              m0_bus_grant;
  logic [ADDR_W-1:0] m0_mst2slv_addr;
  logic [DATA_W-1:0] m0_mst2slv_data;
  logic              m0_mst2slv_wr;
  logic              m0_mst2slv_rd;

  logic              m1_bus_req;
  logic              m1_bus_grant;
  logic [ADDR_W-1:0] m1_mst2slv_addr;
  logic [DATA_W-1:0] m1_mst2slv_data;
  logic              m1_mst2slv_wr;
  logic              m1_mst2slv_rd;

  logic [ADDR_W-1:0] s_mst2slv_addr;
  logic [DATA_W-1:0] s_mst2slv_data;
  logic              s_mst2slv_wr;
  logic              s_mst2slv_rd;
  logic [1:0]        arb_owner;

  modport slave (
    input  m0_bus_req, m0_mst2slv_addr, m0_mst2slv_data, m0_mst2slv_wr, m0_mst2slv_rd,
    input  m1_bus_req, m1_mst2slv_addr, m1_mst2slv_data, m1_mst2slv_wr, m1_mst2slv_rd,
    output m0_bus_grant, m1_bus_grant,
    output s_mst2slv_addr, s_mst2slv_data, s_mst2slv_wr, s_mst2slv_rd, arb_owner
  );

  modport master (
    output m0_bus_req, m0_mst2slv_addr, m0_mst2slv_data, m0_mst2slv_wr, m0_mst2slv_rd,
    output m1_bus_req, m1_mst2slv_addr, m1_mst2slv_data, m1_mst2slv_wr, m1_mst2slv_rd,
    input  m0_bus_grant, m1_bus_grant,
    input  s_mst2slv_addr, s_mst2slv_data, s_mst2slv_wr, s_mst2slv_rd, arb_owner
  );

endinterface

// File: rtl/mst_bus_arbiter.sv
// Two-master bus arbiter with fair tie-breaking and optional grant timeout.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous, active-low reset
//   bus : mst_bus_arbiter_if.slave bundle (requests, grants, slave bus, owner)
// Parameter:
//   TIMEOUT_CYCLES : max continuous grant cycles while the other master
//                    requests; only used when MST_BUS_ARB_TIMEOUT_EN is defined.
// Build option:
//   MST_BUS_ARB_TIMEOUT_EN : adds an 8-bit counter that pre-empts a master
//                            holding the bus while the other one waits.
module mst_bus_arbiter
  import mst_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             clk,
  input logic             rst,
  mst_bus_arbiter_if.slave bus
);

  arb_state_e state;
  arb_state_e state_nxt;
  owner_e     last_owner;
  logic       preempt;

  // State register; grants decode directly from it so reset drops them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Last owner starts as m1 so that m0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWNER_M1;
    end else if (state_nxt == ARB_GNT_M0 && state != ARB_GNT_M0) begin
      last_owner <= OWNER_M0;
    end else if (state_nxt == ARB_GNT_M1 && state != ARB_GNT_M1) begin
      last_owner <= OWNER_M1;
    end
  end

`ifdef MST_BUS_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             other_req;

  always_comb begin
    other_req = 1'b0;
    if (state == ARB_GNT_M0) other_req = bus.m1_bus_req;
    if (state == ARB_GNT_M1) other_req = bus.m0_bus_req;
  end

  // Counts only while the owner keeps the bus and the other master waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state_nxt != state || !other_req) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign preempt = other_req && (to_cnt == TO_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign preempt = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (bus.m0_bus_req && bus.m1_bus_req) begin
          state_nxt = (last_owner == OWNER_M1) ? ARB_GNT_M0 : ARB_GNT_M1;
        end else if (bus.m0_bus_req) begin
          state_nxt = ARB_GNT_M0;
        end else if (bus.m1_bus_req) begin
          state_nxt = ARB_GNT_M1;
        end
      end
      ARB_GNT_M0: begin
        if (!bus.m0_bus_req) begin
          state_nxt = bus.m1_bus_req ? ARB_GNT_M1 : ARB_IDLE;
        end else if (preempt) begin
          state_nxt = ARB_GNT_M1;
        end
      end
      ARB_GNT_M1: begin
        if (!bus.m1_bus_req) begin
          state_nxt = bus.m0_bus_req ? ARB_GNT_M0 : ARB_IDLE;
        end else if (preempt) begin
          state_nxt = ARB_GNT_M0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs: grants and the slave-side mux, all decoded from the registered state.
  always_comb begin
    bus.m0_bus_grant   = 1'b0;
    bus.m1_bus_grant   = 1'b0;
    bus.s_mst2slv_addr = '0;
    bus.s_mst2slv_data = '0;
    bus.s_mst2slv_wr   = 1'b0;
    bus.s_mst2slv_rd   = 1'b0;
    case (state)
      ARB_GNT_M0: begin
        bus.m0_bus_grant   = 1'b1;
        bus.s_mst2slv_addr = bus.m0_mst2slv_addr;
        bus.s_mst2slv_data = bus.m0_mst2slv_data;
        bus.s_mst2slv_wr   = bus.m0_mst2slv_wr;
        bus.s_mst2slv_rd   = bus.m0_mst2slv_rd;
      end
      ARB_GNT_M1: begin
        bus.m1_bus_grant   = 1'b1;
        bus.s_mst2slv_addr = bus.m1_mst2slv_addr;
        bus.s_mst2slv_data = bus.m1_mst2slv_data;
        bus.s_mst2slv_wr   = bus.m1_mst2slv_wr;
        bus.s_mst2slv_rd   = bus.m1_mst2slv_rd;
      end
      default: ;
    endcase
    bus.arb_owner = {bus.m1_bus_grant, bus.m0_bus_grant};
  end

endmodule
